ndp_input_loader: RTL and testbench
===================================

// Module: ndp_input_loader
// PURPOSE
//  Receive side of the NDP_core host load stream. Accepts 32-bit words qualified by data_in_flag,
//  unpacks operand A (A_ROWS x K_DIM) and then operand B (K_DIM x B_COLS) into flat register images.
//  Pulses load_done when both operands are complete.
//  Sits between the host/bus interface and the systolic-array operand inputs inside NDP_core.
// PARAMETERS
//  WIDTH       16   element width (fp16 image, not interpreted here)
//  BUS_WIDTH   32   data_in word width; 2 elements per word at defaults
//  ARR_HEIGHT  4    PE rows per systolic array
//  SYS_HEIGHT  1    systolic arrays vertically; A_ROWS = ARR_HEIGHT*SYS_HEIGHT
//  ARR_WIDTH   4    PE columns per systolic array
//  SYS_WIDTH   64   systolic arrays horizontally; B_COLS = ARR_WIDTH*SYS_WIDTH
//  K_DIM       5    shared dimension (A columns = B rows)
//  Legality: A_ROWS*WIDTH and B_COLS*WIDTH are multiples of BUS_WIDTH.
//  Derived: WA = A_ROWS*WIDTH/BUS_WIDTH (2), WB = B_COLS*WIDTH/BUS_WIDTH (128).
// PORTS
//  clk           in   1                    clock; all state changes on posedge
//  reset         in   1                    asynchronous, active-low reset
//  data_in_flag  in   1                    word valid; data_in is sampled when high
//  data_in       in   BUS_WIDTH            stream word
//  mat_a         out  A_ROWS*K_DIM*WIDTH   A image; elem(r,j) at [WIDTH*(A_ROWS*j+r) +: WIDTH]
//  mat_b         out  K_DIM*B_COLS*WIDTH   B image; elem(j,c) at [WIDTH*(B_COLS*j+c) +: WIDTH]
//  busy          out  1                    high in LOAD_A/LOAD_B after first word accepted
//  load_done     out  1                    one-cycle pulse: both operands complete
//  overrun       out  1                    sticky: word offered during DONE
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, word/col counters=0, mat_a=0, mat_b=0, busy=0,
//    load_done=0, overrun=0.
//  Stream order: A column j=0..K_DIM-1, words i=0..WA-1; then B row j=0..K_DIM-1, words i=0..WB-1.
//  Word i of A column j writes mat_a[A_ROWS*WIDTH*j + BUS_WIDTH*i +: BUS_WIDTH].
//    Same formula with B_COLS for B.
//  So the low half of a word is the lower-index element; no reordering or arithmetic.
//  Acceptance: a word is accepted on every posedge with data_in_flag=1 in IDLE/LOAD_A/LOAD_B.
//    flag=0 cycles are gaps: counters and images hold, no timeout.
//  Image write is registered: the element is visible on mat_a/mat_b the cycle after acceptance.
//  FSM:
//   IDLE   : flag=1 -> accept A word (j=0, i=0); go LOAD_A (or LOAD_B if WA*K_DIM==1).
//   LOAD_A : accept; i wraps at WA-1 with j++.
//            On the last A word (j=K_DIM-1, i=WA-1): counters->0, go LOAD_B.
//   LOAD_B : same with WB.
//            On the last B word: go DONE.
//   DONE   : load_done=1 for exactly this one cycle.
//            flag=1 here is dropped (not written) and sets overrun.
//            Always go IDLE next cycle.
//  busy=1 whenever state is LOAD_A or LOAD_B; load_done=1 iff state==DONE (registered).
//  Latency: load_done rises 1 cycle after the edge accepting the final B word.
//    Minimum back-to-back load = WA*K_DIM + WB*K_DIM + 1 cycles (651 at defaults).
//  Images are not cleared between loads; a new load overwrites every element.
//    Consumers must sample on load_done.
//  overrun is cleared only by reset.
//  Reset mid-load aborts immediately to the reset state; a partially loaded image is discarded (zeroed).
//  Counter widths: clog2 of the max of WA, WB, K_DIM; no wrap beyond the terminal counts is reachable.
// TESTING
//  T1 reset: hold reset=0 with flag toggling -> all outputs 0, state IDLE; release -> still 0.
//  T2 full load, flag continuous:
//     A word (j,i) = {16'(10*j+2*i+1), 16'(10*j+2*i)}; B word = 32'hB000_0000 + 128*j + i.
//     -> mat_a elem(r,j) == 10*j+r; mat_b matches; load_done pulses once, exactly 1 cycle
//     after the 640th B word; busy low in that cycle.
//  T3 gaps: same data with flag=0 on every 3rd cycle -> identical images; load_done delayed by
//     the gap count.
//  T4 overrun: flag held high into DONE with data 32'hDEAD_BEEF -> overrun=1, images unchanged.
//     The following word in IDLE starts a new A load at j=0, i=0.
//  T5 reset mid-load: assert reset after 3 B words -> everything 0 asynchronously, no load_done.
//     A fresh full load then passes the T2 checks.
//  T6 back-to-back: 100 random operand pairs streamed with 1 idle cycle between them
//     -> every image matches at each load_done pulse.

Source files
------------

// File: rtl/ndp_input_loader.sv
// Host load-stream receiver for NDP_core: unpacks operand A (column-major) and then operand B
// (row-major) from BUS_WIDTH words into flat register images, pulsing load_done when complete.
module ndp_input_loader #(
    parameter int WIDTH      = 16,
    parameter int BUS_WIDTH  = 32,
    parameter int ARR_HEIGHT = 4,
    parameter int SYS_HEIGHT = 1,
    parameter int ARR_WIDTH  = 4,
    parameter int SYS_WIDTH  = 64,
    parameter int K_DIM      = 5
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          data_in_flag,
    input  logic [BUS_WIDTH-1:0]                          data_in,
    output logic [ARR_HEIGHT*SYS_HEIGHT*K_DIM*WIDTH-1:0]  mat_a,
    output logic [K_DIM*ARR_WIDTH*SYS_WIDTH*WIDTH-1:0]    mat_b,
    output logic                                          busy,
    output logic                                          load_done,
    output logic                                          overrun
);

    localparam int A_ROWS     = ARR_HEIGHT * SYS_HEIGHT;
    localparam int B_COLS     = ARR_WIDTH * SYS_WIDTH;
    localparam int WA         = A_ROWS * WIDTH / BUS_WIDTH;
    localparam int WB         = B_COLS * WIDTH / BUS_WIDTH;
    localparam int A_BITS     = A_ROWS * K_DIM * WIDTH;
    localparam int B_BITS     = K_DIM * B_COLS * WIDTH;
    localparam int COL_A_BITS = A_ROWS * WIDTH;
    localparam int ROW_B_BITS = B_COLS * WIDTH;
    localparam int MAX_AB     = (WA > WB) ? WA : WB;
    localparam int MAX_CNT    = (MAX_AB > K_DIM) ? MAX_AB : K_DIM;
    localparam int CW         = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       word_q, word_d;
    logic [CW-1:0]       col_q, col_d;
    logic [A_BITS-1:0]   mat_a_q, mat_a_d;
    logic [B_BITS-1:0]   mat_b_q, mat_b_d;
    logic                overrun_q, overrun_d;

    logic                last_word_a;
    logic                last_word_b;
    logic                last_col;
    int                  a_base;
    int                  b_base;

    assign last_word_a = (word_q == CW'(WA - 1));
    assign last_word_b = (word_q == CW'(WB - 1));
    assign last_col    = (col_q == CW'(K_DIM - 1));
    assign a_base      = int'(col_q) * COL_A_BITS + int'(word_q) * BUS_WIDTH;
    assign b_base      = int'(col_q) * ROW_B_BITS + int'(word_q) * BUS_WIDTH;

    // IDLE behaves like LOAD_A with zeroed counters, so the first A word needs no special path.
    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        col_d     = col_q;
        mat_a_d   = mat_a_q;
        mat_b_d   = mat_b_q;
        overrun_d = overrun_q;

        case (state_q)
            IDLE, LOAD_A: begin
                if (data_in_flag) begin
                    mat_a_d[a_base +: BUS_WIDTH] = data_in;
                    if (last_word_a) begin
                        word_d = '0;
                        if (last_col) begin
                            col_d   = '0;
                            state_d = LOAD_B;
                        end else begin
                            col_d   = col_q + CW'(1);
                            state_d = LOAD_A;
                        end
                    end else begin
                        word_d  = word_q + CW'(1);
                        state_d = LOAD_A;
                    end
                end
            end
            LOAD_B: begin
                if (data_in_flag) begin
                    mat_b_d[b_base +: BUS_WIDTH] = data_in;
                    if (last_word_b) begin
                        word_d = '0;
                        if (last_col) begin
                            col_d   = '0;
                            state_d = DONE;
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                    end else begin
                        word_d = word_q + CW'(1);
                    end
                end
            end
            DONE: begin
                // Words offered here are dropped; the host is only told, never stalled.
                if (data_in_flag) begin
                    overrun_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            word_q    <= '0;
            col_q     <= '0;
            mat_a_q   <= '0;
            mat_b_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            col_q     <= col_d;
            mat_a_q   <= mat_a_d;
            mat_b_q   <= mat_b_d;
            overrun_q <= overrun_d;
        end
    end

    assign mat_a     = mat_a_q;
    assign mat_b     = mat_b_q;
    assign busy      = (state_q == LOAD_A) || (state_q == LOAD_B);
    assign load_done = (state_q == DONE);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_ndp_input_loader.sv
// Scoreboard bench for ndp_input_loader: the driver queues expected images per load, and a
// negedge monitor checks them (plus timing and busy) whenever load_done is presented.
module tb_ndp_input_loader;

    localparam int WIDTH     = 16;
    localparam int BUS_WIDTH = 32;
    localparam int A_ROWS    = 4;
    localparam int B_COLS    = 256;
    localparam int K_DIM     = 5;
    localparam int WA        = A_ROWS * WIDTH / BUS_WIDTH;
    localparam int WB        = B_COLS * WIDTH / BUS_WIDTH;
    localparam int A_BITS    = A_ROWS * K_DIM * WIDTH;
    localparam int B_BITS    = K_DIM * B_COLS * WIDTH;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic                  data_in_flag = 1'b0;
    logic [BUS_WIDTH-1:0]  data_in = '0;
    logic [A_BITS-1:0]     mat_a;
    logic [B_BITS-1:0]     mat_b;
    logic                  busy;
    logic                  load_done;
    logic                  overrun;

    ndp_input_loader #(
        .WIDTH(WIDTH), .BUS_WIDTH(BUS_WIDTH), .ARR_HEIGHT(4), .SYS_HEIGHT(1),
        .ARR_WIDTH(4), .SYS_WIDTH(64), .K_DIM(K_DIM)
    ) dut (
        .clk(clk),
        .reset(reset),
        .data_in_flag(data_in_flag),
        .data_in(data_in),
        .mat_a(mat_a),
        .mat_b(mat_b),
        .busy(busy),
        .load_done(load_done),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cycle_cnt = 0;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [A_BITS-1:0] a;
        logic [B_BITS-1:0] b;
        int                cyc;
    } exp_t;

    exp_t              sb[$];
    exp_t              mon_e;
    logic [A_BITS-1:0] exp_a;
    logic [B_BITS-1:0] exp_b;
    logic [31:0]       words[$];
    int                slot = 0;

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic check_img(input string name, input logic [B_BITS-1:0] act,
                             input logic [B_BITS-1:0] req, input int n_elem);
        bit found;
        n_cmp++;
        if (act !== req) begin
            n_err++;
            found = 1'b0;
            for (int k = 0; k < n_elem && !found; k++) begin
                if (act[WIDTH*k +: WIDTH] !== req[WIDTH*k +: WIDTH]) begin
                    $display("[TB] FAIL %s elem %0d: got %h, required %h",
                             name, k, act[WIDTH*k +: WIDTH], req[WIDTH*k +: WIDTH]);
                    found = 1'b1;
                end
            end
            if (!found) $display("[TB] FAIL %s: image differs outside element range", name);
        end
    endtask

    // Monitor: every load_done must match the oldest queued load, on the predicted cycle.
    always @(negedge clk) begin
        if (reset && load_done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("[TB] FAIL unexpected_load_done: got 1 at cycle %0d, required 0", cycle_cnt);
            end else begin
                mon_e = sb.pop_front();
                check_img("mat_a", B_BITS'(mat_a), B_BITS'(mon_e.a), A_ROWS * K_DIM);
                check_img("mat_b", mat_b, mon_e.b, K_DIM * B_COLS);
                check_val("done_cycle", 32'(cycle_cnt), 32'(mon_e.cyc));
                check_val("busy_at_done", 32'(busy), 32'd0);
            end
        end
    end

    // Directed pattern: A elem(r,j) = 10j+r, B word (j,i) = B000_0000 + 128j + i.
    task automatic build_pattern();
        exp_a = '0;
        exp_b = '0;
        words.delete();
        for (int j = 0; j < K_DIM; j++)
            for (int r = 0; r < A_ROWS; r++)
                exp_a[WIDTH*(A_ROWS*j+r) +: WIDTH] = 16'(10*j + r);
        for (int j = 0; j < K_DIM; j++)
            for (int c = 0; c < B_COLS; c++)
                exp_b[WIDTH*(B_COLS*j+c) +: WIDTH] = (c % 2 == 0) ? 16'(128*j + c/2) : 16'hB000;
        for (int j = 0; j < K_DIM; j++)
            for (int i = 0; i < WA; i++)
                words.push_back({16'(10*j + 2*i + 1), 16'(10*j + 2*i)});
        for (int j = 0; j < K_DIM; j++)
            for (int i = 0; i < WB; i++)
                words.push_back(32'hB000_0000 + 32'(128*j + i));
    endtask

    task automatic build_random();
        words.delete();
        for (int k = 0; k < A_ROWS * K_DIM; k++) exp_a[WIDTH*k +: WIDTH] = 16'($urandom);
        for (int k = 0; k < K_DIM * B_COLS; k++) exp_b[WIDTH*k +: WIDTH] = 16'($urandom);
        for (int j = 0; j < K_DIM; j++)
            for (int i = 0; i < WA; i++)
                words.push_back({exp_a[WIDTH*(A_ROWS*j+2*i+1) +: WIDTH],
                                 exp_a[WIDTH*(A_ROWS*j+2*i) +: WIDTH]});
        for (int j = 0; j < K_DIM; j++)
            for (int i = 0; i < WB; i++)
                words.push_back({exp_b[WIDTH*(B_COLS*j+2*i+1) +: WIDTH],
                                 exp_b[WIDTH*(B_COLS*j+2*i) +: WIDTH]});
    endtask

    task automatic send_words(input int count, input bit gaps);
        slot = 0;
        for (int k = 0; k < count; k++) begin
            if (gaps && (slot % 3 == 2)) begin
                data_in_flag = 1'b0;
                data_in      = 32'h5A5A_5A5A;
                @(posedge clk); #1;
                slot++;
            end
            data_in_flag = 1'b1;
            data_in      = words[k];
            @(posedge clk); #1;
            slot++;
            if (k == 0) check_val("busy_after_first_word", 32'(busy), 32'd1);
        end
        data_in_flag = 1'b0;
    endtask

    task automatic issue_load(input bit gaps, input bit overrun_tail);
        exp_t e;
        send_words(words.size(), gaps);
        e.a   = exp_a;
        e.b   = exp_b;
        e.cyc = cycle_cnt;
        sb.push_back(e);
        data_in_flag = overrun_tail;
        data_in      = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        data_in_flag = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_busy"}, 32'(busy), 32'd0);
        check_val({tag, "_load_done"}, 32'(load_done), 32'd0);
        check_val({tag, "_overrun"}, 32'(overrun), 32'd0);
        check_img({tag, "_mat_a"}, B_BITS'(mat_a), '0, A_ROWS * K_DIM);
        check_img({tag, "_mat_b"}, mat_b, '0, K_DIM * B_COLS);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // T1: reset held with flag toggling, then released.
        for (int k = 0; k < 4; k++) begin
            data_in_flag = k[0];
            data_in      = 32'h1234_0000 + 32'(k);
            @(negedge clk);
            check_all_zero("reset_held");
        end
        @(posedge clk); #1;
        data_in_flag = 1'b0;
        reset        = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_released");
        @(posedge clk); #1;

        // T2: full directed load, flag continuous.
        build_pattern();
        issue_load(1'b0, 1'b0);
        check_val("overrun_clean", 32'(overrun), 32'd0);

        // T4: flag held into DONE; the dropped word must not land anywhere.
        build_pattern();
        issue_load(1'b0, 1'b1);
        @(negedge clk);
        check_val("overrun_set", 32'(overrun), 32'd1);
        check_img("overrun_mat_a", B_BITS'(mat_a), B_BITS'(exp_a), A_ROWS * K_DIM);
        check_img("overrun_mat_b", mat_b, exp_b, K_DIM * B_COLS);
        build_random();
        issue_load(1'b0, 1'b0);

        // T3: directed data with a gap on every third cycle.
        build_pattern();
        issue_load(1'b1, 1'b0);

        // T5: reset after three B words.
        build_random();
        send_words(WA * K_DIM + 3, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("midload_reset");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        build_pattern();
        issue_load(1'b0, 1'b0);

        // T6: back-to-back random loads with one idle cycle between them.
        for (int n = 0; n < 100; n++) begin
            build_random();
            issue_load(1'b0, 1'b0);
        end

        repeat (3) @(posedge clk);
        #1;
        check_val("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
